// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: sequences a glitch-free clock mux switchover.
// An accepted request to a different source drives sel_o at once, waits
// SETTLE_CYCLES for the mux to complete the switch (done_o pulses at the end),
// then holds the selection for DWELL_CYCLES before accepting another request.
// A request for the source already selected completes immediately with a
// single done_o pulse and no lockout.
module clk_sel_ctrl #(
   parameter int   SETTLE_CYCLES = 8,
   parameter int   DWELL_CYCLES  = 32,
   parameter logic RESET_SEL     = 1'b0
) (
   input  logic clk_i,
   input  logic arst_ni,
   input  logic req_valid_i,
   input  logic req_sel_i,
   output logic req_ready_o,
   output logic sel_o,
   output logic busy_o,
   output logic done_o
);

   // One counter serves both timed phases, so it is sized for the longer one.
   localparam int MAX_CYCLES = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam bit HAS_DWELL  = (DWELL_CYCLES > 0);

   localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LOAD  = HAS_DWELL ? CW'(DWELL_CYCLES - 1) : {CW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETTLE = 2'b01,
      ST_DWELL  = 2'b10
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r,   cnt_s;
   logic          sel_r,   sel_s;
   logic          done_r,  done_s;

   // State, counter, select and completion pulse registers.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         sel_r   <= RESET_SEL;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         sel_r   <= sel_s;
         done_r  <= done_s;
      end
   end

   // Next-state logic: request acceptance, settle countdown and dwell countdown.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      sel_s   = sel_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (req_sel_i == sel_r) begin
                  // Already on the requested source: complete without lockout.
                  done_s = 1'b1;
               end else begin
                  sel_s   = req_sel_i;
                  state_s = ST_SETTLE;
                  cnt_s   = SETTLE_LOAD;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_r == CNT_ZERO) begin
               done_s = 1'b1;
               if (HAS_DWELL) begin
                  state_s = ST_DWELL;
                  cnt_s   = DWELL_LOAD;
               end else begin
                  state_s = ST_IDLE;
                  cnt_s   = CNT_ZERO;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_DWELL: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_IDLE;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            // Unreachable encoding: recover to a safe idle state.
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   assign req_ready_o = (state_r == ST_IDLE);
   assign busy_o      = (state_r != ST_IDLE);
   assign sel_o       = sel_r;
   assign done_o      = done_r;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Self-checking bench for clk_sel_ctrl: a lockout-window model predicts every
// output each cycle under directed and randomized requests and resets; a second
// instance built without dwell checks the short lockout.
module tb_clk_sel_ctrl;
   localparam int S = 8;
   localparam int D = 32;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic arst_ni, req_valid_i, req_sel_i;
   logic req_ready_o, sel_o, busy_o, done_o;
   logic z_valid, z_sel, z_ready, z_selo, z_busy, z_done;

   clk_sel_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(D), .RESET_SEL(1'b0)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .req_valid_i(req_valid_i), .req_sel_i(req_sel_i),
      .req_ready_o(req_ready_o), .sel_o(sel_o), .busy_o(busy_o), .done_o(done_o));

   clk_sel_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(0), .RESET_SEL(1'b0)) dut0 (
      .clk_i(clk_i), .arst_ni(arst_ni), .req_valid_i(z_valid), .req_sel_i(z_sel),
      .req_ready_o(z_ready), .sel_o(z_selo), .busy_o(z_busy), .done_o(z_done));

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   // Model: selected source, whether a switch lockout is running, edges since acceptance.
   logic m_sel;
   bit   m_locked;
   int   m_since;
   logic m_done;

   task automatic chk(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_sel    = 1'b0;
      m_locked = 1'b0;
      m_since  = 0;
      m_done   = 1'b0;
   endtask

   // One rising edge of the model: accept when unlocked, otherwise count the window.
   task automatic model_edge();
      m_done = 1'b0;
      if (!m_locked) begin
         if (req_valid_i) begin
            if (req_sel_i == m_sel) m_done = 1'b1;
            else begin
               m_sel    = req_sel_i;
               m_locked = 1'b1;
               m_since  = 0;
            end
         end
      end else begin
         m_since++;
         if (m_since == S)     m_done   = 1'b1;
         if (m_since == S + D) m_locked = 1'b0;
      end
   endtask

   task automatic compare_all();
      chk("sel_o", sel_o, m_sel);
      chk("req_ready_o", req_ready_o, !m_locked);
      chk("busy_o", busy_o, m_locked);
      chk("done_o", done_o, m_done);
   endtask

   task automatic cycle();
      @(posedge clk_i);
      cyc++;
      if (arst_ni) model_edge();
      else model_reset();
      #1;
      compare_all();
   endtask

   int acc, d_at, r_at;

   initial begin
      arst_ni     = 1'b0;
      req_valid_i = 1'b0;
      req_sel_i   = 1'b0;
      z_valid     = 1'b0;
      z_sel       = 1'b0;
      model_reset();
      #1;
      compare_all();
      chk("reset_sel_literal", sel_o, 1'b0);
      chk("reset_ready_literal", req_ready_o, 1'b1);
      repeat (3) cycle();
      arst_ni = 1'b1;

      // Idle after reset.
      repeat (5) cycle();

      // Directed switch to clk1: done at k+8, ready again at k+40.
      req_valid_i = 1'b1;
      req_sel_i   = 1'b1;
      cycle();
      acc = cyc;
      req_valid_i = 1'b0;
      chk("switch_sel_literal", sel_o, 1'b1);
      chk("switch_busy_literal", busy_o, 1'b1);
      d_at = -1;
      r_at = -1;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (done_o === 1'b1 && d_at < 0) d_at = cyc;
         if (req_ready_o === 1'b1 && r_at < 0) r_at = cyc;
      end
      chk_int("settle_done_latency", d_at - acc, 8);
      chk_int("lockout_length", r_at - acc, 40);

      // Same-source request: immediate done, no busy.
      req_valid_i = 1'b1;
      req_sel_i   = 1'b1;
      cycle();
      req_valid_i = 1'b0;
      chk("same_done_literal", done_o, 1'b1);
      chk("same_busy_literal", busy_o, 1'b0);
      chk("same_sel_literal", sel_o, 1'b1);
      cycle();
      chk("same_done_clear_literal", done_o, 1'b0);

      // Valid held with toggling select during lockout.
      req_valid_i = 1'b1;
      req_sel_i   = 1'b0;
      for (int i = 0; i < 46; i++) begin
         cycle();
         req_sel_i = ~req_sel_i;
      end
      req_valid_i = 1'b0;
      repeat (45) cycle();

      // Reset five cycles into settle aborts the switch.
      req_valid_i = 1'b1;
      req_sel_i   = ~m_sel;
      cycle();
      req_valid_i = 1'b0;
      repeat (5) cycle();
      arst_ni = 1'b0;
      model_reset();
      #1;
      compare_all();
      chk("abort_sel_literal", sel_o, 1'b0);
      chk("abort_done_literal", done_o, 1'b0);
      repeat (2) cycle();
      arst_ni = 1'b1;
      cycle();
      chk("abort_ready_literal", req_ready_o, 1'b1);

      // Randomized requests with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         req_valid_i = ($urandom_range(0, 2) != 0);
         req_sel_i   = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 399) == 0) begin
            arst_ni = 1'b0;
            model_reset();
            #1;
            compare_all();
            repeat ($urandom_range(1, 3)) cycle();
            arst_ni = 1'b1;
         end
         cycle();
      end
      req_valid_i = 1'b0;
      repeat (45) cycle();

      // Build without dwell: done and ready both return at k+8.
      z_valid = 1'b1;
      z_sel   = 1'b1;
      cycle();
      acc = cyc;
      z_valid = 1'b0;
      chk("nodwell_sel_literal", z_selo, 1'b1);
      chk("nodwell_busy_literal", z_busy, 1'b1);
      d_at = -1;
      r_at = -1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (z_done === 1'b1 && d_at < 0) d_at = cyc;
         if (z_ready === 1'b1 && r_at < 0) r_at = cyc;
      end
      chk_int("nodwell_done_latency", d_at - acc, 8);
      chk_int("nodwell_lockout_length", r_at - acc, 8);
      chk("nodwell_idle_busy", z_busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
